vga_timing_gen: RTL

Parametrised successor of the fixed 640x480 VGA controller. It generates VGA horizontal/vertical timing from parameters: sync, back porch, active and front porch widths, plus sync polarity. It issues pixel-coordinate requests to an upstream framebuffer/renderer with a fixed read latency, then re-aligns sync, blank and colour outputs to the returned data. It sits between the pixel source and the DAC/VGA pins, clocked by the pixel clock.

---
 rtl/vga_pkg.sv | 75 +++++++
 rtl/vga_delay_line.sv | 35 +++
 rtl/vga_timing_gen.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, RGB888 payload layout and colour-bar palette.
package vga_pkg;

    // 640x480@60 timing (25.175 MHz pixel clock)
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;

    // Compact 320x240 timing for quick simulation
    localparam int unsigned TST_H_SYNC   = 16;
    localparam int unsigned TST_H_BP     = 8;
    localparam int unsigned TST_H_ACTIVE = 320;
    localparam int unsigned TST_H_FP     = 8;
    localparam int unsigned TST_V_SYNC   = 2;
    localparam int unsigned TST_V_BP     = 4;
    localparam int unsigned TST_V_ACTIVE = 240;
    localparam int unsigned TST_V_FP     = 2;

    // RGB888 layout: {R,G,B}, red in the top byte
    localparam int unsigned RGB_W  = 24;
    localparam int unsigned COL_W  = 8;
    localparam int unsigned R_LSB  = 16;
    localparam int unsigned G_LSB  = 8;
    localparam int unsigned B_LSB  = 0;
    localparam int unsigned ADDR_W = 10;

    typedef struct packed {
        logic [COL_W-1:0] r;
        logic [COL_W-1:0] g;
        logic [COL_W-1:0] b;
    } rgb_t;

    // Per-pixel control flags carried alongside the colour through the pipeline
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic valid;
        logic frame_start;
        logic line_start;
    } vga_flags_t;

    localparam int unsigned FLAGS_W = $bits(vga_flags_t);

    // Colour-bar palette, left to right
    localparam rgb_t COL_WHITE   = 24'hFF_FF_FF;
    localparam rgb_t COL_YELLOW  = 24'hFF_FF_00;
    localparam rgb_t COL_CYAN    = 24'h00_FF_FF;
    localparam rgb_t COL_GREEN   = 24'h00_FF_00;
    localparam rgb_t COL_MAGENTA = 24'hFF_00_FF;
    localparam rgb_t COL_RED     = 24'hFF_00_00;
    localparam rgb_t COL_BLUE    = 24'h00_00_FF;
    localparam rgb_t COL_BLACK   = 24'h00_00_00;

    // Colour of bar number idx (0 = leftmost)
    function automatic rgb_t bar_colour(input logic [2:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = COL_WHITE;
            3'd1:    c = COL_YELLOW;
            3'd2:    c = COL_CYAN;
            3'd3:    c = COL_GREEN;
            3'd4:    c = COL_MAGENTA;
            3'd5:    c = COL_RED;
            3'd6:    c = COL_BLUE;
            default: c = COL_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// WIDTH x DEPTH shift register with enable and synchronous reset value.
// DEPTH = 0 degenerates to a wire.
module vga_delay_line #(
    parameter int unsigned      WIDTH   = 1,
    parameter int unsigned      DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             pclk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_pass
        logic unused_ctrl;
        assign unused_ctrl = ^{pclk, reset, en};
        assign q_o         = d_i;
    end else begin : g_shift
        logic [WIDTH-1:0] stage_q [DEPTH];

        // Shift one stage per enabled cycle; reset loads the inactive value everywhere
        always_ff @(posedge pclk) begin
            if (reset) begin
                for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= RST_VAL;
            end else if (en) begin
                stage_q[0] <= d_i;
                for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator. Issues pixel requests to a fixed-latency
// source and realigns sync/blank/colour to the returned data.
// Optional build macro VGA_TESTPAT_EN adds testpat_sel and an internal
// colour-bar generator that can replace vga_data.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b0,
    parameter int unsigned DATA_LAT = 1
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              en,
    input  logic [RGB_W-1:0]  vga_data,
`ifdef VGA_TESTPAT_EN
    input  logic              testpat_sel,
`endif
    output logic              req,
    output logic [ADDR_W-1:0] h_addr,
    output logic [ADDR_W-1:0] v_addr,
    output logic              hsync,
    output logic              vsync,
    output logic              valid,
    output logic [COL_W-1:0]  vga_r,
    output logic [COL_W-1:0]  vga_g,
    output logic [COL_W-1:0]  vga_b,
    output logic              frame_start,
    output logic              line_start
);

    localparam int unsigned H_TOTAL  = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_TOTAL  = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int unsigned HCW      = $clog2(H_TOTAL);
    localparam int unsigned VCW      = $clog2(V_TOTAL);
    localparam int unsigned H_ACT_LO = H_SYNC + H_BP;
    localparam int unsigned H_ACT_HI = H_ACT_LO + H_ACTIVE;
    localparam int unsigned V_ACT_LO = V_SYNC + V_BP;
    localparam int unsigned V_ACT_HI = V_ACT_LO + V_ACTIVE;

`ifdef VGA_TESTPAT_EN
    localparam int unsigned PIPE_W = FLAGS_W + RGB_W;
`else
    localparam int unsigned PIPE_W = FLAGS_W;
`endif

    localparam vga_flags_t FLAGS_IDLE = '{hsync: ~H_POL, vsync: ~V_POL,
                                         valid: 1'b0, frame_start: 1'b0,
                                         line_start: 1'b0};
`ifdef VGA_TESTPAT_EN
    localparam logic [PIPE_W-1:0] PIPE_IDLE = {FLAGS_IDLE, RGB_W'(0)};
`else
    localparam logic [PIPE_W-1:0] PIPE_IDLE = FLAGS_IDLE;
`endif

    // Parameter sanity
    if (H_SYNC == 0 || H_BP == 0 || H_ACTIVE == 0 || H_FP == 0 ||
        V_SYNC == 0 || V_BP == 0 || V_ACTIVE == 0 || V_FP == 0) begin : g_err_zero
        $error("vga_timing_gen: timing widths must be non-zero");
    end
    if (DATA_LAT > 7) begin : g_err_lat
        $error("vga_timing_gen: DATA_LAT must be 0..7");
    end
    if (H_ACTIVE > 1024 || V_ACTIVE > 1024) begin : g_err_active
        $error("vga_timing_gen: active area limited to 1024x1024");
    end

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    logic [HCW-1:0] h_cnt_q, h_cnt_d;
    logic [VCW-1:0] v_cnt_q, v_cnt_d;
    logic [31:0]    hc, vc;
    logic           h_last, v_last;

    assign hc     = 32'(h_cnt_q);
    assign vc     = 32'(v_cnt_q);
    assign h_last = (hc == H_TOTAL - 1);
    assign v_last = (vc == V_TOTAL - 1);

    // Next raster position: h wraps every line, v steps on the h wrap
    always_comb begin
        h_cnt_d = h_cnt_q + HCW'(1);
        v_cnt_d = v_cnt_q;
        if (h_last) begin
            h_cnt_d = '0;
            v_cnt_d = v_last ? '0 : v_cnt_q + VCW'(1);
        end
    end

    // Raster position register
    always_ff @(posedge pclk) begin
        if (reset) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else if (en) begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Request stage
    // ------------------------------------------------------------------
    logic              h_sync_rgn, v_sync_rgn, h_act_rgn, v_act_rgn;
    logic              req_d, req_q;
    logic [ADDR_W-1:0] h_addr_d, h_addr_q, v_addr_d, v_addr_q;
    vga_flags_t        flags_d;
    logic [PIPE_W-1:0] pipe_d, pipe_q, pipe_dl;

    assign h_sync_rgn = (hc < H_SYNC);
    assign v_sync_rgn = (vc < V_SYNC);
    assign h_act_rgn  = (hc >= H_ACT_LO) && (hc < H_ACT_HI);
    assign v_act_rgn  = (vc >= V_ACT_LO) && (vc < V_ACT_HI);

    // Decode current position into request address and per-pixel flags
    always_comb begin
        req_d    = h_act_rgn & v_act_rgn;
        h_addr_d = '0;
        v_addr_d = '0;
        if (req_d) begin
            h_addr_d = ADDR_W'(hc - H_ACT_LO);
            v_addr_d = ADDR_W'(vc - V_ACT_LO);
        end
        flags_d             = FLAGS_IDLE;
        flags_d.hsync       = h_sync_rgn ? H_POL : ~H_POL;
        flags_d.vsync       = v_sync_rgn ? V_POL : ~V_POL;
        flags_d.valid       = req_d;
        flags_d.line_start  = req_d && (h_addr_d == '0);
        flags_d.frame_start = req_d && (h_addr_d == '0) && (v_addr_d == '0);
    end

`ifdef VGA_TESTPAT_EN
    localparam int unsigned BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

    logic [31:0] bar_raw;
    logic [2:0]  bar_idx;
    logic        border;
    rgb_t        pat_d;

    // Colour bars with a one-pixel white frame around the active area
    always_comb begin
        bar_raw = 32'(h_addr_d) / BAR_W;
        bar_idx = (bar_raw > 32'd7) ? 3'd7 : 3'(bar_raw);
        border  = (h_addr_d == '0) || (32'(h_addr_d) == H_ACTIVE - 1) ||
                  (v_addr_d == '0) || (32'(v_addr_d) == V_ACTIVE - 1);
        pat_d   = border ? COL_WHITE : bar_colour(bar_idx);
    end

    assign pipe_d = {flags_d, pat_d};
`else
    assign pipe_d = flags_d;
`endif

    // Request registers plus the flags that accompany this request
    always_ff @(posedge pclk) begin
        if (reset) begin
            req_q    <= 1'b0;
            h_addr_q <= '0;
            v_addr_q <= '0;
            pipe_q   <= PIPE_IDLE;
        end else if (en) begin
            req_q    <= req_d;
            h_addr_q <= h_addr_d;
            v_addr_q <= v_addr_d;
            pipe_q   <= pipe_d;
        end
    end

    assign req    = req_q;
    assign h_addr = h_addr_q;
    assign v_addr = v_addr_q;

    // ------------------------------------------------------------------
    // Latency-matching delay line
    // ------------------------------------------------------------------
    vga_delay_line #(
        .WIDTH   (PIPE_W),
        .DEPTH   (DATA_LAT),
        .RST_VAL (PIPE_IDLE)
    ) u_flag_dly (
        .pclk  (pclk),
        .reset (reset),
        .en    (en),
        .d_i   (pipe_q),
        .q_o   (pipe_dl)
    );

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    vga_flags_t flags_dl;
    rgb_t       rgb_src;
    rgb_t       rgb_q;
    logic       hsync_q, vsync_q, valid_q, frame_start_q, line_start_q;

    assign flags_dl = pipe_dl[PIPE_W-1 -: FLAGS_W];

`ifdef VGA_TESTPAT_EN
    assign rgb_src = testpat_sel ? rgb_t'(pipe_dl[RGB_W-1:0]) : rgb_t'(vga_data);
`else
    assign rgb_src = rgb_t'(vga_data);
`endif

    // Final alignment register: flags from the delay line, colour from the source
    always_ff @(posedge pclk) begin
        if (reset) begin
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            valid_q       <= 1'b0;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
            rgb_q         <= '0;
        end else if (en) begin
            hsync_q       <= flags_dl.hsync;
            vsync_q       <= flags_dl.vsync;
            valid_q       <= flags_dl.valid;
            frame_start_q <= flags_dl.frame_start;
            line_start_q  <= flags_dl.line_start;
            rgb_q         <= flags_dl.valid ? rgb_src : '0;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign valid       = valid_q;
    assign frame_start = frame_start_q;
    assign line_start  = line_start_q;
    assign vga_r       = rgb_q.r;
    assign vga_g       = rgb_q.g;
    assign vga_b       = rgb_q.b;

endmodule
